// File: rtl/parallel_bus_pollable_memory_if.sv
// rtl/parallel_bus_pollable_memory_if.sv - control strobes of the 8-bit multiplexed parallel host bus
// Purpose: groups the host-driven transfer controls and the slave acknowledge.
// Signals:
//   read            host -> slave  1 = read transfer, 0 = write transfer
//   register_select host -> slave  0 = address register, 1 = data word
//   enable          host -> slave  transfer strobe, active-high
//   ack_valid       slave -> host  registered acknowledge, one cycle behind enable
interface parallel_bus_pollable_memory_if;
  logic read;
  logic register_select;
  logic enable;
  logic ack_valid;

  modport master (
    output read,
    output register_select,
    output enable,
    input  ack_valid
  );

  modport slave (
    input  read,
    input  register_select,
    input  enable,
    output ack_valid
  );
endinterface

// File: rtl/parallel_bus_pollable_memory.sv
// rtl/parallel_bus_pollable_memory.sv - pollable word memory behind an 8-bit multiplexed parallel bus
// Purpose: the host writes an address, then writes or reads a word of TRANSACTIONS_PER_WORD
//   bytes (most significant byte first) held in a 2^WIDTH-word RAM.
// Ports:
//   clock50_p/clock50_n  differential 50 MHz clock, buffered to clock50
//   reset                synchronous active-high reset on clock50
//   clock10              unused
//   bus                  bidirectional address/data bus, driven only while ctrl.read = 1
//   ctrl                 read/register_select/enable in, ack_valid out
//   lemo/other0/other1   tied low
//   leds                 {ack_valid, write_strobe, checksum, reset, register_select, read, enable, reset50}
module parallel_bus_pollable_memory #(
  parameter int WIDTH = 8,
  parameter int TRANSACTIONS_PER_WORD = 2,
  parameter int LOG2_OF_TRANSACTIONS_PER_WORD = $clog2(TRANSACTIONS_PER_WORD)
) (
  input  logic                                 clock50_p,
  input  logic                                 clock50_n,
  input  logic                                 reset,
  input  logic                                 clock10,
  inout  wire  [WIDTH-1:0]                     bus,
  parallel_bus_pollable_memory_if.slave        ctrl,
  output logic                                 lemo,
  output logic                                 other0,
  output logic                                 other1,
  output logic [7:0]                           leds
);

  localparam int IW = LOG2_OF_TRANSACTIONS_PER_WORD;
  localparam logic [IW-1:0] LAST_INDEX = IW'(TRANSACTIONS_PER_WORD - 1);
  localparam logic [IW-1:0] INDEX_ONE  = IW'(1);

  typedef logic [TRANSACTIONS_PER_WORD-1:0][WIDTH-1:0] word_t;
  localparam word_t CHECKSUM_PATTERN = word_t'(16'h1507);

  // Behavioural stand-in for the differential input buffer.
  wire clock50;
  assign clock50 = clock50_p & ~clock50_n;

  wire unused_clock10;
  assign unused_clock10 = clock10;

  // Internal reset stretched for 9 cycles after reset is released.
  logic       reset50;
  logic [3:0] reset_count;

  always_ff @(posedge clock50) begin
    if (reset) begin
      reset50     <= 1'b1;
      reset_count <= 4'd0;
    end else if (reset50) begin
      reset_count <= reset_count + 4'd1;
      if (reset_count[3]) reset50 <= 1'b0;
    end
  end

  logic [WIDTH-1:0] address, address_n;
  word_t            wdata, wdata_n;
  logic [1:0]       wstate, wstate_n;
  logic [1:0]       rstate, rstate_n;
  logic [IW-1:0]    wword, wword_n;
  logic [IW-1:0]    rword, rword_n;
  logic [WIDTH-1:0] pre_bus, pre_bus_n;
  logic [31:0]      errors, errors_n;
  logic             checksum, checksum_n;
  logic             ack_valid, ack_valid_n;
  logic             write_strobe, write_strobe_n;

  word_t mem [0:(2**WIDTH)-1];
  word_t ram_q;

  // State register.
  always_ff @(posedge clock50) begin
    address      <= address_n;
    wdata        <= wdata_n;
    wstate       <= wstate_n;
    rstate       <= rstate_n;
    wword        <= wword_n;
    rword        <= rword_n;
    pre_bus      <= pre_bus_n;
    errors       <= errors_n;
    checksum     <= checksum_n;
    ack_valid    <= ack_valid_n;
    write_strobe <= write_strobe_n;
  end

  // Next-state logic. wstate/rstate bit 0 = byte of the current pulse taken,
  // bit 1 = final byte of the word in progress.
  always_comb begin
    address_n      = address;
    wdata_n        = wdata;
    wstate_n       = wstate;
    rstate_n       = rstate;
    wword_n        = wword;
    rword_n        = rword;
    pre_bus_n      = pre_bus;
    errors_n       = errors;
    checksum_n     = checksum;
    ack_valid_n    = 1'b0;
    write_strobe_n = 1'b0;

    if (reset || reset50) begin
      address_n  = '0;
      wdata_n    = '0;
      wstate_n   = 2'b00;
      rstate_n   = 2'b00;
      wword_n    = LAST_INDEX;
      rword_n    = LAST_INDEX;
      pre_bus_n  = '0;
      errors_n   = '0;
      checksum_n = 1'b0;
    end else if (ctrl.enable) begin
      ack_valid_n = 1'b1;
      if (ctrl.read) begin
        if (rstate == 2'b00) begin
          pre_bus_n   = ram_q[rword];
          rstate_n[0] = 1'b1;
        end
        if (!rstate[1] && rword == '0) rstate_n[1] = 1'b1;
      end else if (!ctrl.register_select) begin
        address_n = bus;
        // A new address while a word is half transferred aborts that word.
        if (wword != LAST_INDEX || rword != LAST_INDEX) errors_n = errors + 32'd1;
        wstate_n = 2'b00;
        rstate_n = 2'b00;
        wword_n  = LAST_INDEX;
        rword_n  = LAST_INDEX;
      end else begin
        if (wstate == 2'b00) begin
          wdata_n[wword] = bus;
          wstate_n[0]    = 1'b1;
        end
        if (!wstate[1] && wword == '0) wstate_n[1] = 1'b1;
        // Final byte latched on the previous edge: commit the word every
        // cycle the host keeps enable high.
        if (wstate == 2'b11) begin
          write_strobe_n = 1'b1;
          checksum_n     = (wdata == CHECKSUM_PATTERN);
        end
      end
    end else begin
      if (wstate[1]) begin
        wstate_n = 2'b00;
        wword_n  = LAST_INDEX;
      end else if (wstate[0]) begin
        wstate_n[0] = 1'b0;
        wword_n     = wword - INDEX_ONE;
      end
      if (rstate[1]) begin
        rstate_n = 2'b00;
        rword_n  = LAST_INDEX;
      end else if (rstate[0]) begin
        rstate_n[0] = 1'b0;
        rword_n     = rword - INDEX_ONE;
      end
    end
  end

  // Word RAM: stored contents survive reset, only the read register clears.
  always_ff @(posedge clock50) begin
    if (write_strobe) mem[address] <= wdata;
  end

  always_ff @(posedge clock50) begin
    if (reset50) ram_q <= '0;
    else         ram_q <= mem[address];
  end

  // Outputs.
  assign bus = ctrl.read ? pre_bus : {WIDTH{1'bz}};
  assign ctrl.ack_valid = ack_valid;

  always_comb begin
    lemo   = 1'b0;
    other0 = 1'b0;
    other1 = 1'b0;
    leds   = {ack_valid, write_strobe, checksum, reset,
              ctrl.register_select, ctrl.read, ctrl.enable, reset50};
  end

endmodule

// File: tb/tb_parallel_bus_pollable_memory.sv
// tb/tb_parallel_bus_pollable_memory.sv - self-checking bench for parallel_bus_pollable_memory
module tb_parallel_bus_pollable_memory;
  localparam int W = 8;
  localparam int N = 4;

  logic         clock50_p, clock50_n, reset, clock10;
  wire  [W-1:0] bus;
  logic [W-1:0] host_data;
  logic         lemo, other0, other1;
  logic [7:0]   leds;

  parallel_bus_pollable_memory_if ctrl_if();

  // Host drives the bus only for write/address transfers.
  assign bus = ctrl_if.read ? 8'bz : host_data;

  parallel_bus_pollable_memory #(
    .WIDTH(W),
    .TRANSACTIONS_PER_WORD(N),
    .LOG2_OF_TRANSACTIONS_PER_WORD(2)
  ) dut (
    .clock50_p(clock50_p),
    .clock50_n(clock50_n),
    .reset(reset),
    .clock10(clock10),
    .bus(bus),
    .ctrl(ctrl_if),
    .lemo(lemo),
    .other0(other0),
    .other1(other1),
    .leds(leds)
  );

  initial begin
    clock50_p = 1'b0;
    forever #10 clock50_p = ~clock50_p;
  end
  assign clock50_n = ~clock50_p;
  assign clock10   = 1'b0;

  int checks = 0;
  int fails  = 0;

  // Reference model: word store plus abort/error bookkeeping.
  logic [31:0] model_mem [256];
  bit          written   [256];
  int          model_errors = 0;
  bit          pending = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
    logic        exp_checksum;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One enable pulse of len cycles starting at a negedge; returns the last
  // bus value seen and how many in-pulse samples had write_strobe high.
  task automatic pulse(input logic rd, input logic rs, input logic [7:0] data, input int len,
                       output logic [7:0] seen, output int strobes);
    int acks = 0;
    strobes = 0;
    seen = '0;
    ctrl_if.read = rd;
    ctrl_if.register_select = rs;
    host_data = data;
    ctrl_if.enable = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clock50_p);
      acks += int'(ctrl_if.ack_valid);
      strobes += int'(leds[6]);
      seen = bus;
    end
    ctrl_if.enable = 1'b0;
    @(negedge clock50_p);
    check("ack_during_pulse", acks, len);
    check("ack_after_pulse", ctrl_if.ack_valid, 0);
    @(negedge clock50_p);
  endtask

  task automatic addr_phase(input logic [7:0] a);
    logic [7:0] seen;
    int s;
    pulse(1'b0, 1'b0, a, $urandom_range(1, 3), seen, s);
    if (pending) model_errors++;
    pending = 0;
    check("index_after_addr", {dut.wword, dut.rword}, 4'hF);
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] w, input int last_len);
    logic [7:0] seen;
    int s;
    int len;
    addr_phase(a);
    for (int k = N - 1; k >= 0; k--) begin
      len = (k == 0) ? last_len : $urandom_range(1, 3);
      pulse(1'b0, 1'b1, 8'((w >> (8 * k)) & 32'hFF), len, seen, s);
      check($sformatf("write_strobe a=%0h k=%0d", a, k), s, (k == 0) ? len - 1 : 0);
    end
    model_mem[a] = w;
    written[a] = 1'b1;
    check($sformatf("checksum a=%0h", a), leds[5], (w == 32'h1507) ? 1 : 0);
  endtask

  task automatic read_word(input logic [7:0] a, input logic [31:0] exp, input bit do_addr);
    logic [7:0] seen;
    int s;
    if (do_addr) addr_phase(a);
    for (int k = N - 1; k >= 0; k--) begin
      pulse(1'b1, 1'($urandom_range(0, 1)), 8'h00, $urandom_range(1, 3), seen, s);
      check($sformatf("read_byte a=%0h k=%0d", a, k), seen, (exp >> (8 * k)) & 32'hFF);
    end
    ctrl_if.read = 1'b0;
  endtask

  task automatic partial(input logic [7:0] a, input bit is_read, input int nbytes);
    logic [7:0] seen;
    int s;
    addr_phase(a);
    for (int j = 0; j < nbytes; j++)
      pulse(is_read, 1'b1, 8'($urandom()), $urandom_range(1, 3), seen, s);
    ctrl_if.read = 1'b0;
    pending = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit ack_seen;
    logic [7:0] a;
    logic [31:0] w;
    int op;

    vecs[0] = '{8'h4C, 32'h31232A12, 1'b0};
    vecs[1] = '{8'h4D, 32'h31232B34, 1'b0};
    vecs[2] = '{8'h4E, 32'h31232C56, 1'b0};
    vecs[3] = '{8'h4F, 32'h31232D78, 1'b0};
    vecs[4] = '{8'h34, 32'h31231507, 1'b0};
    vecs[5] = '{8'h34, 32'h00001507, 1'b1};

    ctrl_if.read = 1'b0;
    ctrl_if.register_select = 1'b0;
    ctrl_if.enable = 1'b0;
    host_data = 8'h00;
    reset = 1'b1;

    // Reset and the 9-cycle reset50 stretch; enable is ignored throughout.
    repeat (3) @(negedge clock50_p);
    check("reset50_in_reset", leds[0], 1);
    check("ack_in_reset", ctrl_if.ack_valid, 0);
    ctrl_if.enable = 1'b1;
    reset = 1'b0;
    cnt = 0;
    ack_seen = 0;
    while (leds[0] && cnt < 40) begin
      @(negedge clock50_p);
      cnt++;
      if (ctrl_if.ack_valid) ack_seen = 1;
    end
    ctrl_if.enable = 1'b0;
    check("reset50_release_cycles", cnt, 9);
    check("ack_during_reset50", ack_seen, 0);
    @(negedge clock50_p);
    check("leds_idle", leds, 8'h00);
    check("errors_after_reset", dut.errors, 0);
    check("tieoffs", {lemo, other0, other1}, 0);
    host_data = 8'hA5;
    @(negedge clock50_p);
    check("bus_undriven_on_write", bus, 8'hA5);
    ctrl_if.read = 1'b1;
    @(negedge clock50_p);
    check("leds_read_passthrough", leds, 8'h04);
    ctrl_if.read = 1'b0;
    @(negedge clock50_p);

    // Write then read back without re-addressing.
    write_word(vecs[0].addr, vecs[0].word, 3);
    read_word(vecs[0].addr, vecs[0].word, 1'b0);

    // Table: each word written with 3-cycle final pulse, checksum checked.
    for (int i = 1; i < 6; i++) begin
      write_word(vecs[i].addr, vecs[i].word, 3);
      check($sformatf("table_checksum %0d", i), leds[5], vecs[i].exp_checksum);
    end
    for (int i = 0; i < 4; i++) read_word(vecs[i].addr, vecs[i].word, 1'b1);
    read_word(8'h34, vecs[5].word, 1'b1);
    check("errors_table", dut.errors, 0);

    // Aborted write: two of four bytes, then a new address.
    partial(8'h60, 1'b0, 2);
    write_word(8'h61, 32'hCAFE0123, 2);
    check("errors_after_abort", dut.errors, 1);
    read_word(8'h61, 32'hCAFE0123, 1'b1);
    check("errors_model_abort", dut.errors, model_errors);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      a = 8'h80 + 8'($urandom_range(0, 7));
      op = $urandom_range(0, 3);
      if (op == 2 && !written[a]) op = 0;
      case (op)
        0, 1: begin
          w = ($urandom_range(0, 7) == 0) ? 32'h1507 : $urandom();
          write_word(a, w, $urandom_range(2, 4));
        end
        2: read_word(a, model_mem[a], 1'b1);
        default: partial(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      endcase
      check($sformatf("errors_random it=%0d", it), dut.errors, model_errors);
    end

    // Earlier table words must be untouched by everything since.
    for (int i = 0; i < 4; i++) read_word(vecs[i].addr, vecs[i].word, 1'b1);
    check("errors_final", dut.errors, model_errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, fails);
    $finish;
  end

endmodule
